// File: rtl/hilo_pkg.sv
// Shared constants for the HI/LO multiply sequencer: op codes, FSM encoding,
// default datapath width and a small op classification helper.
package hilo_pkg;

   localparam int WIDTH_DEF = 32;

   localparam logic [2:0] OP_NOP   = 3'd0;
   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_MTHI  = 3'd3;
   localparam logic [2:0] OP_MTLO  = 3'd4;
   localparam logic [2:0] OP_MFHI  = 3'd5;
   localparam logic [2:0] OP_MFLO  = 3'd6;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;

   // True for every op that touches HI/LO and therefore must wait for a multiply.
   function automatic logic is_hilo_op(input logic [2:0] op);
      return (op >= OP_MULT) && (op <= OP_MFLO);
   endfunction

endpackage

// File: rtl/hilo_mult_ctrl_sign_fix.sv
// Signed/unsigned operand magnitude and conditional 2*WIDTH negate of the
// unsigned product. Purely combinational.
module sign_fix
   import hilo_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             is_signed,
   output logic [WIDTH-1:0] mag_a,
   output logic [WIDTH-1:0] mag_b,
   output logic             neg_out,
   input  logic [WIDTH-1:0] prod_hi,
   input  logic [WIDTH-1:0] prod_lo,
   input  logic             neg_in,
   output logic [WIDTH-1:0] res_hi,
   output logic [WIDTH-1:0] res_lo
);

   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_fix;

   // The most negative value maps onto itself, which is the correct unsigned
   // magnitude, so no special case is needed.
   always_comb begin
      mag_a   = (is_signed && a_in[WIDTH-1]) ? -a_in : a_in;
      mag_b   = (is_signed && b_in[WIDTH-1]) ? -b_in : b_in;
      neg_out = is_signed & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
   end

   // Full-width two's complement of the product when the signs differed.
   always_comb begin
      prod     = {prod_hi, prod_lo};
      prod_fix = neg_in ? -prod : prod;
      res_hi   = prod_fix[2*WIDTH-1:WIDTH];
      res_lo   = prod_fix[WIDTH-1:0];
   end

endmodule

// File: rtl/hilo_mult_ctrl.sv
// Sequencer between the datapath and the shift-add multiplier: owns HI/LO,
// launches multiplies, applies sign correction and raises HI/LO hazard stalls.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | accepting ops; MTHI/MTLO/MFHI/MFLO served here
//   ST_START | mul_start high for one cycle, watchdog loaded
//   ST_WAIT  | waiting for mul_ready, watchdog counting down
module hilo_mult_ctrl
   import hilo_pkg::*;
#(
   parameter int WIDTH      = WIDTH_DEF,
   parameter int WAIT_LIMIT = 40
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             op_valid,
   input  logic [2:0]       op_code,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   output logic             stall,
   output logic             busy,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   output logic [WIDTH-1:0] hi_q,
   output logic [WIDTH-1:0] lo_q,
   output logic             err,
   output logic             mul_start,
   output logic [WIDTH-1:0] mul_a,
   output logic [WIDTH-1:0] mul_b,
   input  logic [WIDTH-1:0] mul_lo,
   input  logic [WIDTH-1:0] mul_hi,
   input  logic             mul_ready
);

   localparam int CW = $clog2(WAIT_LIMIT + 1);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] hi_d, lo_d;
   logic [WIDTH-1:0] mul_a_q, mul_a_d;
   logic [WIDTH-1:0] mul_b_q, mul_b_d;
   logic             mul_start_q, mul_start_d;
   logic             neg_q, neg_d;
   logic             err_q, err_d;
   logic [CW-1:0]    wait_cnt_q, wait_cnt_d;

   logic [WIDTH-1:0] mag_a, mag_b;
   logic             neg_calc;
   logic [WIDTH-1:0] res_hi, res_lo;

   sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
      .a_in      (rs_val),
      .b_in      (rt_val),
      .is_signed (op_code == OP_MULT),
      .mag_a     (mag_a),
      .mag_b     (mag_b),
      .neg_out   (neg_calc),
      .prod_hi   (mul_hi),
      .prod_lo   (mul_lo),
      .neg_in    (neg_q),
      .res_hi    (res_hi),
      .res_lo    (res_lo)
   );

   assign busy      = (state_q != ST_IDLE);
   assign stall     = op_valid & busy & is_hilo_op(op_code);
   assign err       = err_q;
   assign mul_start = mul_start_q;
   assign mul_a     = mul_a_q;
   assign mul_b     = mul_b_q;

   // Next-state and register-update logic; mul_ready only matters in ST_WAIT.
   always_comb begin
      state_d     = state_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      mul_a_d     = mul_a_q;
      mul_b_d     = mul_b_q;
      mul_start_d = 1'b0;
      neg_d       = neg_q;
      err_d       = err_q;
      wait_cnt_d  = wait_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (op_valid) begin
               case (op_code)
                  OP_MULT, OP_MULTU: begin
                     mul_a_d     = mag_a;
                     mul_b_d     = mag_b;
                     neg_d       = neg_calc;
                     mul_start_d = 1'b1;
                     state_d     = ST_START;
                  end
                  OP_MTHI: hi_d = rs_val;
                  OP_MTLO: lo_d = rs_val;
                  default: ;
               endcase
            end
         end
         ST_START: begin
            wait_cnt_d = CW'(WAIT_LIMIT - 1);
            state_d    = ST_WAIT;
         end
         ST_WAIT: begin
            if (mul_ready) begin
               hi_d    = res_hi;
               lo_d    = res_lo;
               state_d = ST_IDLE;
            end else if (wait_cnt_q == '0) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               wait_cnt_d = wait_cnt_q - CW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // MFHI/MFLO read path, valid only when the op is served in ST_IDLE.
   always_comb begin
      rd_valid = 1'b0;
      rd_data  = '0;
      if (op_valid && (state_q == ST_IDLE)) begin
         if (op_code == OP_MFHI) begin
            rd_valid = 1'b1;
            rd_data  = hi_q;
         end else if (op_code == OP_MFLO) begin
            rd_valid = 1'b1;
            rd_data  = lo_q;
         end
      end
   end

   // State and architectural registers; reset aborts any multiply in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         hi_q        <= '0;
         lo_q        <= '0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         mul_start_q <= 1'b0;
         neg_q       <= 1'b0;
         err_q       <= 1'b0;
         wait_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         mul_a_q     <= mul_a_d;
         mul_b_q     <= mul_b_d;
         mul_start_q <= mul_start_d;
         neg_q       <= neg_d;
         err_q       <= err_d;
         wait_cnt_q  <= wait_cnt_d;
      end
   end

endmodule

// File: tb/tb_hilo_mult_ctrl.sv
// Directed bench for hilo_mult_ctrl with a 32-step shift-add multiplier model.
module tb_hilo_mult_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        op_valid;
   logic [2:0]  op_code;
   logic [31:0] rs_val, rt_val;
   logic        stall, busy, rd_valid, err, mul_start, mul_ready;
   logic [31:0] rd_data, hi_q, lo_q, mul_a, mul_b, mul_lo, mul_hi;
   logic        kill_ready;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   hilo_mult_ctrl #(.WIDTH(32), .WAIT_LIMIT(40)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .op_valid  (op_valid),
      .op_code   (op_code),
      .rs_val    (rs_val),
      .rt_val    (rt_val),
      .stall     (stall),
      .busy      (busy),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .hi_q      (hi_q),
      .lo_q      (lo_q),
      .err       (err),
      .mul_start (mul_start),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_lo    (mul_lo),
      .mul_hi    (mul_hi),
      .mul_ready (mul_ready)
   );

   // Shift-add multiplier without reset: loads on mul_start, 32 steps, ready = count MSB.
   logic [63:0] m_p;
   logic [31:0] m_a;
   logic [5:0]  m_cnt = 6'd32;
   logic [32:0] m_sum;
   assign m_sum     = {1'b0, m_p[63:32]} + (m_p[0] ? {1'b0, m_a} : 33'd0);
   assign mul_hi    = m_p[63:32];
   assign mul_lo    = m_p[31:0];
   assign mul_ready = m_cnt[5] & ~kill_ready;
   always @(posedge clk) begin
      if (mul_start) begin
         m_a   <= mul_a;
         m_p   <= {32'd0, mul_b};
         m_cnt <= 6'd0;
      end else if (!m_cnt[5]) begin
         m_p   <= {m_sum, m_p[31:1]};
         m_cnt <= m_cnt + 6'd1;
      end
   end

   typedef struct {
      logic [2:0]  op;
      logic [31:0] rs, rt, ma, mb, hi, lo;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic v, input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
      op_valid = v;
      op_code  = op;
      rs_val   = rs;
      rt_val   = rt;
   endtask

   // Wait for busy to fall; returns edges taken, bounded.
   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 80) begin
         tick();
         n++;
      end
   endtask

   task automatic do_mult(input vec_t v);
      int n;
      set_op(1'b1, v.op, v.rs, v.rt);
      #1;
      chk("accept_no_stall", 64'(stall), 64'd0);
      tick();
      set_op(1'b0, 3'd0, 32'd0, 32'd0);
      chk("busy_after_accept", 64'(busy), 64'd1);
      chk("mul_start_pulse", 64'(mul_start), 64'd1);
      chk("mul_a", 64'(mul_a), 64'(v.ma));
      chk("mul_b", 64'(mul_b), 64'(v.mb));
      tick();
      chk("mul_start_single", 64'(mul_start), 64'd0);
      wait_idle(n);
      chk("mult_latency", 64'(n + 1), 64'd34);
      chk("hi_result", 64'(hi_q), 64'(v.hi));
      chk("lo_result", 64'(lo_q), 64'(v.lo));
   endtask

   initial begin
      int n;
      vecs[0] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      vecs[1] = '{3'd1, 32'hFFFFFFFD, 32'd5,        32'd3,        32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
      vecs[2] = '{3'd1, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      vecs[3] = '{3'd1, 32'h80000000, 32'd1,        32'h80000000, 32'd1,        32'hFFFFFFFF, 32'h80000000};
      vecs[4] = '{3'd1, 32'd7,        32'hFFFFFFFF, 32'd7,        32'd1,        32'hFFFFFFFF, 32'hFFFFFFF9};
      vecs[5] = '{3'd2, 32'h80000000, 32'd2,        32'h80000000, 32'd2,        32'h00000001, 32'h00000000};
      vecs[6] = '{3'd1, 32'd0,        32'hFFFFFFFB, 32'd0,        32'd5,        32'h00000000, 32'h00000000};
      vecs[7] = '{3'd1, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd2,        32'd3,        32'h00000000, 32'h00000006};

      kill_ready = 1'b0;
      rst_n = 1'b0;
      set_op(1'b0, 3'd0, 32'd0, 32'd0);
      repeat (3) tick();
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_hi", 64'(hi_q), 64'd0);
      chk("rst_lo", 64'(lo_q), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_mul_start", 64'(mul_start), 64'd0);
      chk("rst_mul_a", 64'(mul_a), 64'd0);
      chk("rst_rd_valid", 64'(rd_valid), 64'd0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 8; i++) do_mult(vecs[i]);

      // Hazards during a multiply: stalled ops must have no side effect.
      set_op(1'b1, 3'd1, 32'hFFFFFFFD, 32'd5);
      tick();
      set_op(1'b1, 3'd5, 32'd0, 32'd0);
      #1;
      chk("mfhi_busy_stall", 64'(stall), 64'd1);
      chk("mfhi_busy_rd_valid", 64'(rd_valid), 64'd0);
      chk("mfhi_busy_rd_data", 64'(rd_data), 64'd0);
      set_op(1'b1, 3'd0, 32'd0, 32'd0);
      #1;
      chk("nop_busy_stall", 64'(stall), 64'd0);
      set_op(1'b1, 3'd7, 32'd0, 32'd0);
      #1;
      chk("op7_busy_stall", 64'(stall), 64'd0);
      set_op(1'b1, 3'd4, 32'hDEADBEEF, 32'd0);
      #1;
      chk("mtlo_busy_stall", 64'(stall), 64'd1);
      tick();
      chk("mtlo_busy_lo_kept", 64'(lo_q), 64'h6);
      set_op(1'b0, 3'd0, 32'd0, 32'd0);
      wait_idle(n);
      chk("hazard_wait_done", 64'(busy), 64'd0);
      set_op(1'b1, 3'd5, 32'd0, 32'd0);
      #1;
      chk("mfhi_after_rd_data", 64'(rd_data), 64'hFFFFFFFF);
      chk("mfhi_after_rd_valid", 64'(rd_valid), 64'd1);
      chk("mfhi_after_stall", 64'(stall), 64'd0);
      tick();

      // MTHI then MFHI; MTLO then MFLO.
      set_op(1'b1, 3'd3, 32'h12345678, 32'd0);
      tick();
      set_op(1'b1, 3'd5, 32'd0, 32'd0);
      #1;
      chk("mthi_mfhi_rd_data", 64'(rd_data), 64'h12345678);
      chk("mthi_mfhi_rd_valid", 64'(rd_valid), 64'd1);
      chk("mthi_mfhi_stall", 64'(stall), 64'd0);
      set_op(1'b1, 3'd4, 32'hAAAA5555, 32'd0);
      tick();
      set_op(1'b1, 3'd6, 32'd0, 32'd0);
      #1;
      chk("mtlo_mflo_rd_data", 64'(rd_data), 64'hAAAA5555);
      chk("mtlo_hi_kept", 64'(hi_q), 64'h12345678);
      set_op(1'b1, 3'd7, 32'h0, 32'd0);
      #1;
      chk("op7_rd_valid", 64'(rd_valid), 64'd0);
      tick();
      chk("op7_no_effect", 64'({hi_q, lo_q}), 64'h12345678AAAA5555);
      set_op(1'b0, 3'd0, 32'd0, 32'd0);

      // Reset in the middle of WAIT, then a clean restart.
      set_op(1'b1, 3'd2, 32'd9, 32'd9);
      tick();
      set_op(1'b0, 3'd0, 32'd0, 32'd0);
      repeat (11) tick();
      chk("midop_busy_before", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("midop_rst_busy", 64'(busy), 64'd0);
      chk("midop_rst_hilo", 64'({hi_q, lo_q}), 64'd0);
      tick();
      rst_n = 1'b1;
      tick();
      do_mult(vecs[4]);

      // Watchdog: multiplier never reports ready.
      kill_ready = 1'b1;
      set_op(1'b1, 3'd2, 32'd3, 32'd3);
      tick();
      set_op(1'b0, 3'd0, 32'd0, 32'd0);
      n = 0;
      while (busy && n < 80) begin
         if (n == 39) chk("wd_err_not_early", 64'(err), 64'd0);
         tick();
         n++;
      end
      chk("wd_cycles", 64'(n), 64'd41);
      chk("wd_err", 64'(err), 64'd1);
      chk("wd_busy", 64'(busy), 64'd0);
      chk("wd_hilo_kept", 64'({hi_q, lo_q}), 64'hFFFFFFFFFFFFFFF9);
      kill_ready = 1'b0;
      do_mult(vecs[7]);
      chk("err_sticky", 64'(err), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("err_cleared_by_rst", 64'(err), 64'd0);
      tick();
      rst_n = 1'b1;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hilo_mult_ctrl.md
Name: hilo_mult_ctrl

Overview:
- Sequencer between the multi-cycle MIPS datapath and the 32-cycle shift-add multiplier.
- Accepts MULT/MULTU/MTHI/MTLO/MFHI/MFLO from the decode/execute stage.
- For MULT/MULTU: converts signed operands to magnitudes, pulses the multiplier start, waits for ready, applies sign correction, and writes the architectural HI/LO registers.
- Generates the datapath stall for HI/LO hazards.

Parameters:
- WIDTH, 32: operand/HI/LO width; the multiplier product is 2*WIDTH.
- WAIT_LIMIT, 40: maximum cycles in WAIT before the watchdog error is flagged.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- op_valid  in  1  operation request this cycle
- op_code  in  3  0 NOP, 1 MULT, 2 MULTU, 3 MTHI, 4 MTLO, 5 MFHI, 6 MFLO; 7 ignored
- rs_val  in  WIDTH  rs operand
- rt_val  in  WIDTH  rt operand
- stall  out  1  request not accepted this cycle; hold it
- busy  out  1  multiply in flight
- rd_data  out  WIDTH  MFHI/MFLO result
- rd_valid  out  1  rd_data valid this cycle
- hi_q  out  WIDTH  architectural HI
- lo_q  out  WIDTH  architectural LO
- err  out  1  sticky watchdog error
- mul_start  out  1  start pulse to the multiplier
- mul_a  out  WIDTH  multiplicand magnitude
- mul_b  out  WIDTH  multiplier magnitude
- mul_lo  in  WIDTH  multiplier product low
- mul_hi  in  WIDTH  multiplier product high
- mul_ready  in  1  multiplier done (counter MSB)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE
  - hi_q=lo_q=0, mul_start=0, mul_a=mul_b=0, err=0, wait counter=0
  - The multiplier has no reset, so mul_ready is ignored outside WAIT.
- States: IDLE, START, WAIT.
- IDLE:
  - op_valid with op 1/2: register mul_a=|rs|, mul_b=|rt| and neg = (rs[31]^rt[31]) for MULT, 0 for MULTU; go to START.
  - Magnitude of 0x80000000 is 0x80000000, treated as unsigned.
- START:
  - mul_start=1 for exactly one cycle; wait counter cleared; go to WAIT.
  - mul_ready is not sampled in START, because it still shows the previous operation's value.
- WAIT:
  - Counter increments each cycle.
  - When mul_ready=1: at that edge {hi_q,lo_q} = neg ? -{mul_hi,mul_lo} (64-bit two's complement) : {mul_hi,mul_lo}; go to IDLE.
  - If the counter reaches WAIT_LIMIT first: set err=1, go to IDLE, leave HI/LO unchanged.
- Latency: acceptance edge E0, multiplier loads at E1, result written at E34; busy=1 from after E0 through E34.
- busy = (state != IDLE).
- A new MULT can be accepted in the first IDLE cycle after writeback.
- stall is combinational: stall = op_valid & busy & op in {1..6}. A stalled op has no side effects.
- MTHI/MTLO in IDLE: hi_q/lo_q = rs_val at the edge.
- MFHI/MFLO in IDLE:
  - rd_data = hi_q/lo_q combinationally, rd_valid=1 the same cycle.
  - Otherwise rd_valid=0 and rd_data=0.
- MFHI in the same cycle as an MTHI is impossible (single op per cycle).
- MFHI in the cycle after MTHI returns the new value.
- NOP/op 7: no effect, no stall.
- Reset mid-operation: immediate return to IDLE; the next MULT restarts the multiplier cleanly via mul_start.
- err is cleared only by reset.

Decomposition:
- Shared package hilo_pkg:
  - op_code constants (OP_NOP..OP_MFLO)
  - state encoding
  - WIDTH default
- One natural sub-module, sign_fix: operand magnitude plus conditional 64-bit negate, purely combinational.
- The FSM and registers stay in hilo_mult_ctrl.
- The bench instantiates the real multiplier as the mul_* partner.

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> mul_start one cycle after acceptance; at E34 hi_q=0xFFFFFFFE, lo_q=0x00000001; busy high 34 cycles.
- MULT rs=0xFFFFFFFD(-3), rt=5 -> mul_a=3, mul_b=5; hi_q=0xFFFFFFFF, lo_q=0xFFFFFFF1.
- MULT rs=0x80000000, rt=0x80000000 -> hi_q=0x40000000, lo_q=0x00000000; MULT 0x80000000*1 -> hi_q=0xFFFFFFFF, lo_q=0x80000000.
- MFHI and MTLO issued during busy -> stall=1, rd_valid=0, lo_q unchanged; reissued after writeback -> rd_data=new hi_q, rd_valid=1.
- MTHI rs=0x12345678 in IDLE, then MFHI next cycle -> rd_data=0x12345678, rd_valid=1, stall=0.
- rst_n low at WAIT cycle 10 -> state IDLE, hi_q=lo_q=0, busy=0; separately, mul_ready tied 0 -> err=1 after 40 WAIT cycles, busy drops.
